// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: issues loads and stores to the data memory over a
// req/ack handshake, stalls the pipeline while an access is outstanding, and
// registers the retired result into the MEM/WB bundle.
//
// Handshake: dmem_req is registered and stays high from the edge after an
// access is detected until the edge after the cycle in which dmem_ack is
// seen (or the timeout abort). dmem_addr/dmem_wdata/dmem_we are stable for
// that whole window. dmem_ack completes the request in the cycle it is high
// and is ignored when no request is outstanding.
module mem_access_ctrl #(
  parameter int PC_WIDTH      = 15,
  parameter int DATA_WIDTH    = 16,
  parameter int REGADDR_WIDTH = 4,
  parameter int TIMEOUT       = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_reg_write,
  input  logic                     mem_mem_read,
  input  logic                     mem_mem_write,
  input  logic [PC_WIDTH-1:0]      mem_pc,
  input  logic [DATA_WIDTH-1:0]    mem_alu_result,
  input  logic [DATA_WIDTH-1:0]    mem_write_data,
  input  logic [REGADDR_WIDTH-1:0] mem_rd,
  output logic                     stall,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [DATA_WIDTH-1:0]    dmem_addr,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  input  logic                     dmem_ack,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  output logic                     wb_reg_write,
  output logic [REGADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]    wb_result,
  output logic [PC_WIDTH-1:0]      wb_pc,
  output logic                     mem_err,
  output logic                     dbg_state
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;

  logic                    w_access;
  logic                    w_store;
  logic                    w_stall;
  logic                    w_start;
  logic                    w_retire_alu;
  logic                    w_retire_mem;
  logic                    w_abort;

  logic                    r_req;
  logic                    r_we;
  logic [DATA_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_wb_reg_write;
  logic [REGADDR_WIDTH-1:0] r_wb_rd;
  logic [DATA_WIDTH-1:0]   r_wb_result;
  logic [PC_WIDTH-1:0]     r_wb_pc;
  logic                    r_err;

  // A store wins when both read and write are flagged.
  assign w_access = mem_mem_read | mem_mem_write;
  assign w_store  = mem_mem_write;

  // State register and timeout counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, counter and per-cycle control decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_stall      = 1'b0;
    w_start      = 1'b0;
    w_retire_alu = 1'b0;
    w_retire_mem = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          w_stall     = 1'b1;
          w_start     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_BUSY;
        end else begin
          w_retire_alu = 1'b1;
        end
      end
      S_BUSY: begin
        if (dmem_ack) begin
          w_retire_mem = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_abort     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Memory request, latched access operands and MEM/WB bundle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_req          <= 1'b0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_wb_reg_write <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_result    <= '0;
      r_wb_pc        <= '0;
      r_err          <= 1'b0;
    end else begin
      r_err <= w_abort;
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= w_store;
        r_addr  <= mem_alu_result;
        r_wdata <= mem_write_data;
      end else if (w_retire_mem || w_abort) begin
        r_req <= 1'b0;
      end
      if (w_retire_alu) begin
        r_wb_reg_write <= mem_reg_write;
        r_wb_rd        <= mem_rd;
        r_wb_pc        <= mem_pc;
        r_wb_result    <= mem_alu_result;
      end else if (w_retire_mem) begin
        r_wb_reg_write <= mem_reg_write;
        r_wb_rd        <= mem_rd;
        r_wb_pc        <= mem_pc;
        r_wb_result    <= r_we ? mem_alu_result : dmem_rdata;
      end else begin
        // Bubble while an access is pending, and on abort.
        r_wb_reg_write <= 1'b0;
      end
    end
  end

  assign stall        = reset & w_stall;
  assign dmem_req     = r_req;
  assign dmem_we      = r_we;
  assign dmem_addr    = r_addr;
  assign dmem_wdata   = r_wdata;
  assign wb_reg_write = r_wb_reg_write;
  assign wb_rd        = r_wb_rd;
  assign wb_result    = r_wb_result;
  assign wb_pc        = r_wb_pc;
  assign mem_err      = r_err;
  assign dbg_state    = (r_state == S_BUSY);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases plus random instruction mix with
// random memory latency, checked against a per-instruction timing model.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int PW = 15;
  localparam int DW = 16;
  localparam int RW = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mem_reg_write, mem_mem_read, mem_mem_write;
  logic [PW-1:0] mem_pc;
  logic [DW-1:0] mem_alu_result, mem_write_data;
  logic [RW-1:0] mem_rd;
  logic          stall, dmem_req, dmem_we;
  logic [DW-1:0] dmem_addr, dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic          wb_reg_write;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_result;
  logic [PW-1:0] wb_pc;
  logic          mem_err;
  logic          dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected retired results, in program order.
  logic [DW-1:0] exp_q[$];
  // Expected MEM/WB contents after the most recent edge.
  logic          exp_rw;
  logic [RW-1:0] exp_rd;
  logic [PW-1:0] exp_pc;
  logic [DW-1:0] exp_res;

  // Clock
  always #5 clk = ~clk;

  mem_access_ctrl #(
    .PC_WIDTH(PW), .DATA_WIDTH(DW), .REGADDR_WIDTH(RW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_pc(mem_pc),
    .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
    .mem_rd(mem_rd), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_result(wb_result), .wb_pc(wb_pc), .mem_err(mem_err),
    .dbg_state(dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_wb();
    check_eq("wb_reg_write", wb_reg_write, exp_rw);
    check_eq("wb_rd", wb_rd, exp_rd);
    check_eq("wb_pc", wb_pc, exp_pc);
    check_eq("wb_result", wb_result, exp_res);
  endtask

  // Presents one instruction and holds it as the pipeline would while stall
  // is high. lat = number of waiting BUSY cycles before ack; lat >= TO means
  // the memory never answers.
  task automatic run_instr(input logic rw, input logic [RW-1:0] rd,
                           input logic [PW-1:0] pc, input logic [DW-1:0] alu,
                           input logic [DW-1:0] wd, input logic rd_en,
                           input logic wr_en, input int lat,
                           input logic [DW-1:0] rdata);
    bit access;
    bit store;
    bit acked;
    int stalls;
    access = rd_en | wr_en;
    store  = wr_en;
    acked  = 1'b0;
    stalls = 0;
    if (!access || lat < TO) exp_q.push_back((access && !store) ? rdata : alu);
    mem_reg_write  = rw;
    mem_rd         = rd;
    mem_pc         = pc;
    mem_alu_result = alu;
    mem_write_data = wd;
    mem_mem_read   = rd_en;
    mem_mem_write  = wr_en;
    // Any ack while idle must be ignored.
    dmem_ack       = 1'($urandom_range(0, 1));
    dmem_rdata     = DW'($urandom);
    @(negedge clk);
    check_eq("req_low_idle", dmem_req, 0);
    if (!access) begin
      check_eq("alu_stall", stall, 0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check_eq("alu_mem_err", mem_err, 0);
      exp_rw = rw; exp_rd = rd; exp_pc = pc; exp_res = exp_q.pop_front();
    end else begin
      check_eq("detect_stall", stall, 1);
      stalls = 1;
      @(posedge clk); #1;
      check_eq("err_pulse_end", mem_err, 0);
      for (int b = 0; b < TO; b++) begin
        dmem_ack   = (b == lat);
        dmem_rdata = (b == lat) ? rdata : DW'($urandom);
        @(negedge clk);
        check_eq("busy_req", dmem_req, 1);
        check_eq("busy_addr", dmem_addr, alu);
        check_eq("busy_we", dmem_we, store);
        check_eq("busy_wdata", dmem_wdata, wd);
        check_eq("busy_bubble", wb_reg_write, 0);
        check_eq("busy_state", dbg_state, 1);
        if (stall) stalls++;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        if (b == lat) begin
          acked = 1'b1;
          break;
        end
      end
      check_eq("stall_cycles", stalls, acked ? 1 + lat : TO);
      check_eq("req_drop", dmem_req, 0);
      check_eq("state_idle", dbg_state, 0);
      check_eq("mem_err", mem_err, acked ? 0 : 1);
      if (acked) begin
        exp_rw = rw; exp_rd = rd; exp_pc = pc; exp_res = exp_q.pop_front();
      end else begin
        exp_rw = 1'b0;
      end
    end
    check_wb();
  endtask

  task automatic rand_instr();
    int kind;
    int lat;
    kind = $urandom_range(0, 9);
    lat  = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 4);
    run_instr(1'($urandom), RW'($urandom), PW'($urandom), DW'($urandom),
              DW'($urandom), (kind >= 4 && kind <= 6) || kind == 9,
              kind >= 7, lat, DW'($urandom));
  endtask

  // Reset asserted for three cycles while an access is outstanding.
  task automatic reset_in_busy();
    mem_reg_write = 1'b1; mem_rd = 4'd9; mem_pc = 15'h0123;
    mem_alu_result = 16'h0200; mem_write_data = 16'h0; mem_mem_read = 1'b1;
    mem_mem_write = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("pre_rst_busy", dbg_state, 1);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_stall", stall, 0);
      @(posedge clk); #1;
    end
    check_eq("rst_req", dmem_req, 0);
    check_eq("rst_state", dbg_state, 0);
    exp_rw = 1'b0; exp_rd = '0; exp_pc = '0; exp_res = '0;
    exp_q.delete();
    check_wb();
    // Late ack after reset with no access presented: ignored.
    mem_mem_read = 1'b0; mem_reg_write = 1'b1; mem_rd = 4'd3;
    mem_pc = 15'h0044; mem_alu_result = 16'h0777;
    dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
    reset = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check_eq("late_ack_req", dmem_req, 0);
    check_eq("late_ack_state", dbg_state, 0);
    exp_rw = 1'b1; exp_rd = 4'd3; exp_pc = 15'h0044; exp_res = 16'h0777;
    check_wb();
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_mem_write = 1'b0;
    mem_pc = '0; mem_alu_result = '0; mem_write_data = '0; mem_rd = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_stall0", stall, 0);
    check_eq("rst_req0", dmem_req, 0);
    check_eq("rst_we0", dmem_we, 0);
    check_eq("rst_addr0", dmem_addr, 0);
    check_eq("rst_wdata0", dmem_wdata, 0);
    check_eq("rst_err0", mem_err, 0);
    check_eq("rst_state0", dbg_state, 0);
    exp_rw = 1'b0; exp_rd = '0; exp_pc = '0; exp_res = '0;
    check_wb();
    reset = 1'b1;

    // ALU op
    run_instr(1'b1, 4'd5, 15'h0100, 16'h1234, 16'h0, 1'b0, 1'b0, 0, 16'h0);
    // Load, ack on third BUSY cycle
    run_instr(1'b1, 4'd7, 15'h0104, 16'h0040, 16'h0, 1'b1, 1'b0, 2, 16'hBEEF);
    // Store, zero-wait, no register write
    run_instr(1'b0, 4'd0, 15'h0108, 16'h0010, 16'hA5A5, 1'b0, 1'b1, 0, 16'h0);
    // Load that never gets an ack
    run_instr(1'b1, 4'd2, 15'h010C, 16'h0080, 16'h0, 1'b1, 1'b0, TO, 16'h0);
    // Back-to-back load then store, one wait each
    run_instr(1'b1, 4'd4, 15'h0110, 16'h0050, 16'h0, 1'b1, 1'b0, 1, 16'h1357);
    run_instr(1'b0, 4'd6, 15'h0114, 16'h0060, 16'h2468, 1'b0, 1'b1, 1, 16'h0);
    // Read and write both flagged: treated as a store
    run_instr(1'b1, 4'd8, 15'h0118, 16'h0070, 16'h9999, 1'b1, 1'b1, 0, 16'hFFFF);

    for (int i = 0; i < 80; i++) rand_instr();
    reset_in_busy();
    for (int i = 0; i < 20; i++) rand_instr();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
